iguana_usb_padmux: RTL and testbench
====================================

Name: iguana_usb_padmux

Overview:
Sequenced pad-sharing controller between Cheshire's 32-bit GPIO and its USB ports on the wired GPIO pads.
- Each USB port owns two pads: dm on pad 2p, dp on pad 2p+1.
- Ownership is requested by GPIO output bits EnBitOffset+p.
- On every ownership change, a per-port FSM runs a turnaround with all drivers released, so GPIO and USB never fight on a pad.
- Sits in iguana_soc between cheshire_soc (GPIO/USB side) and the pad-facing GPIO ports.

Parameters:
- NumPorts, 4, number of USB ports sharing pads (equals UsbNumPorts).
- NumPads, 32, core-side GPIO width; pad-side width is also NumPads, and the SoC truncates to GpioNumWired outside this block.
- EnBitOffset, 28, GPIO output bit index of the port 0 enable; port p uses EnBitOffset+p.
- TurnCycles, 4, turnaround length in clk_i cycles; legal range 1..255.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- gpio_core_o_i  in  NumPads  GPIO output values from the core
- gpio_core_en_i  in  NumPads  GPIO output enables from the core
- gpio_core_i_o  out  NumPads  pad input values to the core
- usb_dm_o_i, usb_dp_o_i  in  NumPorts  USB drive values
- usb_dm_oe_i, usb_dp_oe_i  in  NumPorts  USB output enables
- usb_dm_i_o, usb_dp_i_o  out  NumPorts  USB receive values
- pad_i  in  NumPads  pad input values
- pad_o  out  NumPads  pad output values
- pad_en_o  out  NumPads  pad output enables
- usb_active_o  out  NumPorts  port p currently owns its pads
- busy_o  out  NumPorts  port p in a turnaround

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Input pass-through: gpio_core_i_o = pad_i at all times, unconditionally and combinationally.
- Per-port FSM states: GPIO, G2U, USB, U2G. A per-port turn counter is 8 bits wide.
- Enable sampling: en_p = gpio_core_o_i[EnBitOffset+p], sampled at clk_i edges only.

FSM transitions:
- GPIO: when en_p=1 at an edge → G2U, counter loads TurnCycles-1.
- USB: when en_p=0 at an edge → U2G, counter loads TurnCycles-1.
- G2U and U2G: decrement each cycle. At an edge with counter==0, the next state is chosen from en_p at that edge: 1 → USB, 0 → GPIO.
  - A request that reverses mid-turn never shortens or extends the turn.
  - The port then lands in whatever state the request asks for at turn end.
  - No state is skipped: GPIO→USB always passes through G2U.
- Turn length: a turn state lasts exactly TurnCycles cycles. Example: en_p rises before edge k → G2U during cycles k..k+TurnCycles-1 → USB from cycle k+TurnCycles.

Pad mux for pads 2p and 2p+1 (combinational from state):
- GPIO: pad_o/pad_en_o follow gpio_core_o_i/gpio_core_en_i. usb_dm_i_o[p]=0, usb_dp_i_o[p]=1 (idle J state).
- G2U, U2G: pad_o=0, pad_en_o=0. USB receive values held at idle (dm=0, dp=1).
- USB: pad 2p = usb_dm_o_i[p]/usb_dm_oe_i[p], pad 2p+1 = usb_dp_o_i[p]/usb_dp_oe_i[p]. usb_dm_i_o[p]=pad_i[2p], usb_dp_i_o[p]=pad_i[2p+1].

Other outputs:
- Pads ≥ 2*NumPorts always follow the core GPIO unchanged, including the enable bits themselves.
- usb_active_o[p] = (state==USB).
- busy_o[p] = (state∈{G2U,U2G}).
- Ports are fully independent. Simultaneous requests on all ports are legal and turn in parallel.

Reset:
- All FSMs go to GPIO and all counters to 0.
- Outputs then take their GPIO-state values combinationally: usb_active_o=0, busy_o=0, usb_dm_i_o=0, usb_dp_i_o=all-ones.
- Reset mid-turn aborts immediately to GPIO with no turnaround.

Decomposition:
- iguana_pkg adds:
  - UsbEnBitOffset (28)
  - UsbPadTurnCycles (4)
  - the usb_pad_state_e enum {GPIO, G2U, USB, U2G}
- Sub-module iguana_usb_pad_port: one FSM, counter and pair mux per port, instantiated NumPorts times by a generate loop.
- The top level handles pass-through pads and input routing.

Test Plan:
1. Reset, all inputs 0, gpio_core_o_i=32'h0000_00A5, gpio_core_en_i=all ones → pad_o=32'h0000_00A5, pad_en_o=all ones, usb_dp_i_o=4'hF, usb_dm_i_o=0, usb_active_o=0.
2. Set bit 28 before edge k, TurnCycles=4 → pads 0/1 pad_en_o=0 and busy_o[0]=1 for cycles k..k+3. From k+4: usb_active_o[0]=1, pad_o[1:0]={usb_dp_o_i[0],usb_dm_o_i[0]}, and pad_i[1:0]=2'b01 gives usb_dm_i_o[0]=1, usb_dp_i_o[0]=0.
3. Set bit 29, clear it 2 cycles into G2U → 4-cycle turn completes, port 1 returns to GPIO, usb_active_o[1] never asserts.
4. Bits 28–31 set in the same cycle → all four ports busy for the same 4 cycles, all active at k+4. Pads 8..31 keep following the core throughout.
5. Assert rst_ni low for 1 cycle during U2G on port 2 → busy_o[2]=0 and pads 4/5 follow the core immediately, asynchronously.
6. Port 3 in USB, clear bit 31 → U2G for 4 cycles with pads 6/7 pad_en_o=0, then GPIO drive resumes.

Source files
------------

// File: rtl/iguana_pkg.sv
// Shared SoC constants and types used by the USB/GPIO pad-sharing logic.
package iguana_pkg;

  localparam int unsigned UsbEnBitOffset   = 28;
  localparam int unsigned UsbPadTurnCycles = 4;

  typedef enum logic [1:0] {
    GPIO = 2'd0,
    G2U  = 2'd1,
    USB  = 2'd2,
    U2G  = 2'd3
  } usb_pad_state_e;

endpackage

// File: rtl/iguana_usb_pad_port.sv
// One USB port's ownership FSM and pad-pair mux. Drivers are released for a
// fixed number of cycles on every ownership change so GPIO and USB never fight.
module iguana_usb_pad_port
  import iguana_pkg::*;
#(
  parameter int unsigned TurnCycles = UsbPadTurnCycles
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] gpio_o_i,
  input  logic [1:0] gpio_en_i,
  input  logic [1:0] pad_i,
  input  logic       usb_dm_o_i,
  input  logic       usb_dm_oe_i,
  input  logic       usb_dp_o_i,
  input  logic       usb_dp_oe_i,
  output logic [1:0] pad_o,
  output logic [1:0] pad_en_o,
  output logic       usb_dm_i_o,
  output logic       usb_dp_i_o,
  output logic       active_o,
  output logic       busy_o
);

  localparam logic [7:0] TurnLoad = 8'(TurnCycles - 1);

  usb_pad_state_e state_reg;
  logic [7:0]     cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= GPIO;
      cnt_reg   <= 8'd0;
    end else begin
      case (state_reg)
        GPIO: if (en_i) begin
          state_reg <= G2U;
          cnt_reg   <= TurnLoad;
        end
        USB: if (!en_i) begin
          state_reg <= U2G;
          cnt_reg   <= TurnLoad;
        end
        G2U, U2G: begin
          // Turn length is fixed; only the landing state follows the request.
          if (cnt_reg == 8'd0) state_reg <= en_i ? USB : GPIO;
          else                 cnt_reg   <= cnt_reg - 8'd1;
        end
        default: state_reg <= GPIO;
      endcase
    end
  end

  always_comb begin
    pad_o      = gpio_o_i;
    pad_en_o   = gpio_en_i;
    usb_dm_i_o = 1'b0;
    usb_dp_i_o = 1'b1;
    case (state_reg)
      G2U, U2G: begin
        pad_o    = 2'b00;
        pad_en_o = 2'b00;
      end
      USB: begin
        pad_o      = {usb_dp_o_i, usb_dm_o_i};
        pad_en_o   = {usb_dp_oe_i, usb_dm_oe_i};
        usb_dm_i_o = pad_i[0];
        usb_dp_i_o = pad_i[1];
      end
      default: ;
    endcase
  end

  assign active_o = (state_reg == USB);
  assign busy_o   = (state_reg == G2U) || (state_reg == U2G);

endmodule

// File: rtl/iguana_usb_padmux.sv
// Pad-sharing controller between the core GPIO and the USB ports. Each port
// owns pads 2p/2p+1 when requested; all other pads pass the core GPIO through.
module iguana_usb_padmux
  import iguana_pkg::*;
#(
  parameter int unsigned NumPorts    = 4,
  parameter int unsigned NumPads     = 32,
  parameter int unsigned EnBitOffset = UsbEnBitOffset,
  parameter int unsigned TurnCycles  = UsbPadTurnCycles
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumPads-1:0]  gpio_core_o_i,
  input  logic [NumPads-1:0]  gpio_core_en_i,
  output logic [NumPads-1:0]  gpio_core_i_o,
  input  logic [NumPorts-1:0] usb_dm_o_i,
  input  logic [NumPorts-1:0] usb_dp_o_i,
  input  logic [NumPorts-1:0] usb_dm_oe_i,
  input  logic [NumPorts-1:0] usb_dp_oe_i,
  output logic [NumPorts-1:0] usb_dm_i_o,
  output logic [NumPorts-1:0] usb_dp_i_o,
  input  logic [NumPads-1:0]  pad_i,
  output logic [NumPads-1:0]  pad_o,
  output logic [NumPads-1:0]  pad_en_o,
  output logic [NumPorts-1:0] usb_active_o,
  output logic [NumPorts-1:0] busy_o
);

  assign gpio_core_i_o = pad_i;

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_port
    iguana_usb_pad_port #(
      .TurnCycles(TurnCycles)
    ) i_port (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (gpio_core_o_i[EnBitOffset+gi]),
      .gpio_o_i   (gpio_core_o_i[2*gi +: 2]),
      .gpio_en_i  (gpio_core_en_i[2*gi +: 2]),
      .pad_i      (pad_i[2*gi +: 2]),
      .usb_dm_o_i (usb_dm_o_i[gi]),
      .usb_dm_oe_i(usb_dm_oe_i[gi]),
      .usb_dp_o_i (usb_dp_o_i[gi]),
      .usb_dp_oe_i(usb_dp_oe_i[gi]),
      .pad_o      (pad_o[2*gi +: 2]),
      .pad_en_o   (pad_en_o[2*gi +: 2]),
      .usb_dm_i_o (usb_dm_i_o[gi]),
      .usb_dp_i_o (usb_dp_i_o[gi]),
      .active_o   (usb_active_o[gi]),
      .busy_o     (busy_o[gi])
    );
  end

  // Upper pads, including the enable request bits, are never muxed.
  if (NumPads > 2 * NumPorts) begin : g_pass
    assign pad_o[NumPads-1:2*NumPorts]    = gpio_core_o_i[NumPads-1:2*NumPorts];
    assign pad_en_o[NumPads-1:2*NumPorts] = gpio_core_en_i[NumPads-1:2*NumPorts];
  end

endmodule

// File: tb/tb_iguana_usb_padmux.sv
// Directed table-driven bench for the USB/GPIO pad-sharing controller.
module tb_iguana_usb_padmux;

  typedef struct packed {
    logic [31:0] gpio_o;
    logic [31:0] pad_in;
    logic [31:0] exp_pad_o;
    logic [31:0] exp_pad_en;
    logic [3:0]  exp_dm;
    logic [3:0]  exp_dp;
    logic [3:0]  exp_active;
    logic [3:0]  exp_busy;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] gpio_core_o_i, gpio_core_en_i, gpio_core_i_o;
  logic [3:0]  usb_dm_o_i, usb_dp_o_i, usb_dm_oe_i, usb_dp_oe_i;
  logic [3:0]  usb_dm_i_o, usb_dp_i_o, usb_active_o, busy_o;
  logic [31:0] pad_i, pad_o, pad_en_o;

  int checks = 0;
  int errors = 0;
  vec_t vecs [26];

  always #5 clk_i = ~clk_i;

  iguana_usb_padmux #(
    .NumPorts(4), .NumPads(32), .EnBitOffset(28), .TurnCycles(4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .gpio_core_o_i (gpio_core_o_i),
    .gpio_core_en_i(gpio_core_en_i),
    .gpio_core_i_o (gpio_core_i_o),
    .usb_dm_o_i    (usb_dm_o_i),
    .usb_dp_o_i    (usb_dp_o_i),
    .usb_dm_oe_i   (usb_dm_oe_i),
    .usb_dp_oe_i   (usb_dp_oe_i),
    .usb_dm_i_o    (usb_dm_i_o),
    .usb_dp_i_o    (usb_dp_i_o),
    .pad_i         (pad_i),
    .pad_o         (pad_o),
    .pad_en_o      (pad_en_o),
    .usb_active_o  (usb_active_o),
    .busy_o        (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_rows(input int first, input int last, input logic [31:0] g,
                          input logic [31:0] pi, input logic [31:0] po,
                          input logic [31:0] pe, input logic [3:0] dm,
                          input logic [3:0] dp, input logic [3:0] act,
                          input logic [3:0] bsy);
    for (int i = first; i <= last; i++) vecs[i] = '{g, pi, po, pe, dm, dp, act, bsy};
  endtask

  task automatic check_all(input string tag, input logic [31:0] po, input logic [31:0] pe,
                           input logic [3:0] dm, input logic [3:0] dp,
                           input logic [3:0] act, input logic [3:0] bsy);
    check({tag, " pad_o"}, pad_o, po);
    check({tag, " pad_en_o"}, pad_en_o, pe);
    check({tag, " usb_dm_i_o"}, 32'(usb_dm_i_o), 32'(dm));
    check({tag, " usb_dp_i_o"}, 32'(usb_dp_i_o), 32'(dp));
    check({tag, " usb_active_o"}, 32'(usb_active_o), 32'(act));
    check({tag, " busy_o"}, 32'(busy_o), 32'(bsy));
    check({tag, " gpio_core_i_o"}, gpio_core_i_o, pad_i);
  endtask

  initial begin
    // Port pads in USB: port p drives {dp,dm}; dm_oe=1, dp_oe=0 per port.
    set_rows( 0,  0, 32'h0000_00A5, 32'h0000_0000, 32'h0000_00A5, 32'hFFFF_FFFF, 4'h0, 4'hF, 4'h0, 4'h0);
    set_rows( 1,  4, 32'h1000_00A5, 32'h0000_0001, 32'h1000_00A4, 32'hFFFF_FFFC, 4'h0, 4'hF, 4'h0, 4'h1);
    set_rows( 5,  5, 32'h1000_00A5, 32'h0000_0001, 32'h1000_00A6, 32'hFFFF_FFFD, 4'h1, 4'hE, 4'h1, 4'h0);
    set_rows( 6,  7, 32'h3000_00A5, 32'h0000_0001, 32'h3000_00A2, 32'hFFFF_FFF1, 4'h1, 4'hE, 4'h1, 4'h2);
    set_rows( 8,  9, 32'h1000_00A5, 32'h0000_0001, 32'h1000_00A2, 32'hFFFF_FFF1, 4'h1, 4'hE, 4'h1, 4'h2);
    set_rows(10, 10, 32'h1000_00A5, 32'h0000_0002, 32'h1000_00A6, 32'hFFFF_FFFD, 4'h0, 4'hF, 4'h1, 4'h0);
    set_rows(11, 14, 32'h0000_00A5, 32'h0000_0000, 32'h0000_00A4, 32'hFFFF_FFFC, 4'h0, 4'hF, 4'h0, 4'h1);
    set_rows(15, 15, 32'h0000_00A5, 32'h5A5A_0000, 32'h0000_00A5, 32'hFFFF_FFFF, 4'h0, 4'hF, 4'h0, 4'h0);
    set_rows(16, 19, 32'hF000_00A5, 32'h0000_0000, 32'hF000_0000, 32'hFFFF_FF00, 4'h0, 4'hF, 4'h0, 4'hF);
    set_rows(20, 20, 32'hF000_00A5, 32'h0000_00C1, 32'hF000_0066, 32'hFFFF_FF55, 4'h9, 4'h8, 4'hF, 4'h0);
    set_rows(21, 24, 32'h7000_00A5, 32'h0000_0001, 32'h7000_0026, 32'hFFFF_FF15, 4'h1, 4'h8, 4'h7, 4'h8);
    set_rows(25, 25, 32'h7000_00A5, 32'h0000_0001, 32'h7000_00A6, 32'hFFFF_FFD5, 4'h1, 4'h8, 4'h7, 4'h0);

    rst_ni         = 1'b0;
    gpio_core_o_i  = 32'h0000_00A5;
    gpio_core_en_i = 32'hFFFF_FFFF;
    pad_i          = 32'h0;
    usb_dm_o_i     = 4'hA;
    usb_dp_o_i     = 4'h5;
    usb_dm_oe_i    = 4'hF;
    usb_dp_oe_i    = 4'h0;
    #2;
    check_all("reset", 32'h0000_00A5, 32'hFFFF_FFFF, 4'h0, 4'hF, 4'h0, 4'h0);
    $display("reset state checked: pad_o=%h busy=%h", pad_o, busy_o);

    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 26; i++) begin
      @(negedge clk_i);
      gpio_core_o_i = vecs[i].gpio_o;
      pad_i         = vecs[i].pad_in;
      @(posedge clk_i);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_pad_o, vecs[i].exp_pad_en,
                vecs[i].exp_dm, vecs[i].exp_dp, vecs[i].exp_active, vecs[i].exp_busy);
      $display("vec %0d: gpio_o=%h pad_o=%h pad_en=%h active=%h busy=%h",
               i, gpio_core_o_i, pad_o, pad_en_o, usb_active_o, busy_o);
    end

    // Port 2 starts U2G, then an asynchronous reset aborts it mid-turn.
    @(negedge clk_i);
    gpio_core_o_i = 32'h3000_00A5;
    @(posedge clk_i);
    #1;
    check("u2g port2 busy_o", 32'(busy_o), 32'h4);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all("async reset", 32'h3000_00A5, 32'hFFFF_FFFF, 4'h0, 4'hF, 4'h0, 4'h0);
    $display("async reset mid-turn: busy=%h pad_o=%h", busy_o, pad_o);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("post reset busy_o", 32'(busy_o), 32'h3);
    check("post reset usb_active_o", 32'(usb_active_o), 32'h0);
    $display("post reset: busy=%h active=%h", busy_o, usb_active_o);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
